// File: rtl/fetch_instr_packer_pkg.sv
// Shared fetch-stage types: the queue entry layout and the default fetch group width.
// Imported by the packer, its inflight counter and the bench.
package cpu_defs;

    localparam int FETCH_WIDTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_instr_packer_if.sv
// Bundle of I-cache response, flush/request and multi-queue push signals around the packer.
// The slave modport is the packer; the master modport is the surrounding fetch stage.
interface fetch_instr_packer_if #(
    parameter int FETCH_WIDTH  = cpu_defs::FETCH_WIDTH,
    parameter int PUSH_CHANNEL = 3
);
    localparam int SW = $clog2(FETCH_WIDTH);
    localparam int NW = $clog2(PUSH_CHANNEL + 1);

    logic                                    flush;
    logic                                    req_fire;
    logic                                    inflight_full;
    logic                                    resp_valid;
    logic                                    resp_ready;
    logic [31:0]                             resp_pc;
    logic [SW-1:0]                           resp_start;
    logic [FETCH_WIDTH*32-1:0]               resp_instr;
    logic [FETCH_WIDTH-1:0]                  resp_taken;
    logic                                    queue_full;
    cpu_defs::fetch_entry_t [PUSH_CHANNEL-1:0] data_push;
    logic [NW-1:0]                           push_num;
    logic                                    stall_push;

    modport master (
        output flush, req_fire, resp_valid, resp_pc, resp_start, resp_instr, resp_taken, queue_full,
        input  inflight_full, resp_ready, data_push, push_num, stall_push
    );

    modport slave (
        input  flush, req_fire, resp_valid, resp_pc, resp_start, resp_instr, resp_taken, queue_full,
        output inflight_full, resp_ready, data_push, push_num, stall_push
    );

endinterface

// File: rtl/fetch_instr_packer_inflight_ctr.sv
// Outstanding I-cache request counter plus stale-response drop counter loaded on flush.
// Latency: counters update at the next edge; dropping/inflight_full are registered-state decodes.
// Backpressure: none; the PC generator must honour inflight_full.
module fetch_inflight_ctr #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_fire,
    input  logic resp_fire,
    input  logic flush,
    output logic dropping,
    output logic inflight_full
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0] outst;
    logic [CW-1:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            outst    <= '0;
            drop_cnt <= '0;
        end else begin
            outst <= outst + CW'(req_fire) - CW'(resp_fire);
            // Every request still outstanding at flush time is older than the redirect.
            if (flush) begin
                drop_cnt <= outst - CW'(resp_fire);
            end else if (resp_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    assign dropping      = (drop_cnt != '0);
    assign inflight_full = (outst == CW'(MAX_INFLIGHT));

endmodule

// File: rtl/fetch_instr_packer.sv
// Trims each I-cache fetch group to its live slot range and drains it into the instruction queue.
// Latency: first push one cycle after the response is accepted; FETCH_BRANCH_CUT_EN cuts after a taken branch's delay slot.
// Backpressure: queue_full freezes the buffer; resp_ready drops until the buffered group can finish this cycle.
module fetch_instr_packer
    import cpu_defs::*;
#(
    parameter int FETCH_WIDTH  = cpu_defs::FETCH_WIDTH,
    parameter int PUSH_CHANNEL = 3,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_instr_packer_if.slave  fp
);
    localparam int SW = $clog2(FETCH_WIDTH);
    localparam int CW = SW + 1;
    localparam int NW = $clog2(PUSH_CHANNEL + 1);

    logic                      buf_valid;
    logic [31:0]               buf_pc;
    logic [FETCH_WIDTH*32-1:0] buf_instr;
    logic [FETCH_WIDTH-1:0]    buf_taken;
    logic [SW-1:0]             lo;
    logic [SW-1:0]             hi;

    logic                      dropping;
    logic                      resp_fire;
    logic                      capture;
    logic [CW-1:0]             avail;
    logic [NW-1:0]             n_beat;
    logic [NW-1:0]             push_cnt;
    logic [SW-1:0]             end_slot;
    logic [SW-1:0]             slot;
    fetch_entry_t [PUSH_CHANNEL-1:0] data_push_c;

    fetch_inflight_ctr #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_inflight (
        .clk          (clk),
        .rst          (rst),
        .req_fire     (fp.req_fire),
        .resp_fire    (resp_fire),
        .flush        (fp.flush),
        .dropping     (dropping),
        .inflight_full(fp.inflight_full)
    );

    assign avail    = {1'b0, hi} - {1'b0, lo} + CW'(1);
    assign n_beat   = (avail > CW'(PUSH_CHANNEL)) ? NW'(PUSH_CHANNEL) : NW'(avail);
    assign push_cnt = (buf_valid && !fp.queue_full && !fp.flush) ? n_beat : '0;

    // Accept a new group only if the current one finishes draining this very cycle.
    assign fp.resp_ready = dropping || !buf_valid || (!fp.queue_full && (avail <= CW'(PUSH_CHANNEL)));
    assign resp_fire     = fp.resp_valid && fp.resp_ready;
    assign capture       = resp_fire && !dropping && !fp.flush;

`ifdef FETCH_BRANCH_CUT_EN
    logic found;
    always_comb begin
        end_slot = SW'(FETCH_WIDTH - 1);
        found    = 1'b0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (!found && (SW'(k) >= fp.resp_start) && fp.resp_taken[k]) begin
                found = 1'b1;
                // A taken branch in the last slot keeps the whole group; its delay slot comes next group.
                if (k < FETCH_WIDTH - 1) end_slot = SW'(k + 1);
            end
        end
    end
`else
    assign end_slot = SW'(FETCH_WIDTH - 1);
`endif

    always_comb begin
        data_push_c = '0;
        slot        = '0;
        for (int i = 0; i < PUSH_CHANNEL; i++) begin
            if (NW'(i) < push_cnt) begin
                slot                      = lo + SW'(i);
                data_push_c[i].pc         = buf_pc + 32'({slot, 2'b00});
                data_push_c[i].instr      = buf_instr[32*slot +: 32];
                data_push_c[i].pred_taken = buf_taken[slot];
            end
        end
    end

    assign fp.data_push  = data_push_c;
    assign fp.push_num   = push_cnt;
    assign fp.stall_push = fp.queue_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            lo        <= '0;
            hi        <= '0;
        end else if (fp.flush) begin
            buf_valid <= 1'b0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            lo        <= fp.resp_start;
            hi        <= end_slot;
        end else if (buf_valid) begin
            lo <= lo + SW'(push_cnt);
            if (({1'b0, lo} + CW'(push_cnt)) > {1'b0, hi}) buf_valid <= 1'b0;
        end
    end

    // Payload only matters while buf_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_pc    <= fp.resp_pc;
            buf_instr <= fp.resp_instr;
            buf_taken <= fp.resp_taken;
        end
    end

endmodule
